// File: rtl/sp1_pkg.sv
// Shared widths, opcode encodings and store-handshake state type for the
// SP1 core's memory controller.
package sp1_pkg;

  localparam int INSTR_W = 11;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 8;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    ADD = 3'd1,
    SUB = 3'd2,
    JC  = 3'd4,
    JZ  = 3'd5,
    JMP = 3'd6,
    LD  = 3'd7
  } opcode_e;

  // Opcode sits in the top bits; an all-zero word therefore decodes as HLT.
  localparam logic [INSTR_W-1:0] INSTR_HLT = {HLT, {(INSTR_W-3){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_WAIT_LOW
  } st_state_e;

endpackage

// File: rtl/sp1_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// Only the read register is reset; the array itself keeps its contents.
module sp1_ram #(
  parameter int                WIDTH   = 8,
  parameter int                DEPTH   = 16,
  parameter logic [WIDTH-1:0]  RST_VAL = '0,
  localparam int               AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Non-blocking read of the array gives read-before-write on an address clash.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      rdata_q <= RST_VAL;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sp1_memctl.sv
// SP1 memory controller: instruction fetch RAM with loader port, plus a
// level-handshaked store path writing into a debug-readable log buffer.
module sp1_memctl
  import sp1_pkg::*;
#(
  parameter int  LOG_DEPTH  = 16,
  parameter int  IMEM_DEPTH = 256,
  localparam int LOG_AW     = $clog2(LOG_DEPTH),
  localparam int IMEM_AW    = $clog2(IMEM_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               st_req,
  input  logic [DATA_W-1:0]  st_data,
  output logic               st_ack,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic [LOG_AW-1:0]  rd_addr,
  output logic [DATA_W-1:0]  rd_data,
  output logic [LOG_AW:0]    log_count,
  output logic               overflow
);

  localparam logic [LOG_AW:0] FULL_COUNT = (LOG_AW + 1)'(LOG_DEPTH);

  st_state_e         state_q, state_d;
  logic [LOG_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_AW:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              instr_valid_q;
  logic              log_we;

  // Fetch path: a loader write freezes the fetch register for that cycle.
  sp1_ram #(
    .WIDTH   (INSTR_W),
    .DEPTH   (IMEM_DEPTH),
    .RST_VAL (INSTR_HLT)
  ) u_imem (
    .clk     (clk),
    .rst_i   (rst),
    .we_i    (prog_we),
    .waddr_i (prog_addr[IMEM_AW-1:0]),
    .wdata_i (prog_data),
    .re_i    (~prog_we),
    .raddr_i (pc[IMEM_AW-1:0]),
    .rdata_o (instr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_valid_q <= 1'b0;
    end else begin
      instr_valid_q <= ~prog_we;
    end
  end

  assign instr_valid = instr_valid_q;

  sp1_ram #(
    .WIDTH   (DATA_W),
    .DEPTH   (LOG_DEPTH),
    .RST_VAL ('0)
  ) u_log (
    .clk     (clk),
    .rst_i   (rst),
    .we_i    (log_we & ~rst),
    .waddr_i (wr_ptr_q),
    .wdata_i (st_data),
    .re_i    (1'b1),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  // Reset lands in WAIT_LOW so a request held across reset must drop first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_WAIT_LOW;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    log_we     = 1'b0;
    st_ack     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (st_req) begin
          state_d = ST_ACK;
          if (count_q != FULL_COUNT) begin
            log_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + LOG_AW'(1);
            count_d  = count_q + (LOG_AW + 1)'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      ST_ACK: begin
        st_ack  = 1'b1;
        state_d = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (!st_req) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_WAIT_LOW;
    endcase
  end

  assign log_count = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_sp1_memctl.sv
// Self-checking bench for sp1_memctl with a 4-entry log: vector table,
// directed handshake/overflow/reset sequences, then randomized cycles.
module tb_sp1_memctl;

  logic        clk;
  logic        rst;
  logic [7:0]  pc;
  logic [10:0] instr;
  logic        instr_valid;
  logic        st_req;
  logic [7:0]  st_data;
  logic        st_ack;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [10:0] prog_data;
  logic [1:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [2:0]  log_count;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;

  sp1_memctl #(
    .LOG_DEPTH  (4),
    .IMEM_DEPTH (256)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .st_req      (st_req),
    .st_data     (st_data),
    .st_ack      (st_ack),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .log_count   (log_count),
    .overflow    (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [10:0] prog_data;
    logic [7:0]  pc;
    logic        st_req;
    logic [7:0]  st_data;
    logic [1:0]  rd_addr;
    logic [10:0] exp_instr;
    logic        exp_iv;
    logic        exp_ack;
    logic [2:0]  exp_cnt;
    logic        chk_rd;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs[12];

  // Reference model state: memories as arrays, the handshake as "armed".
  logic [10:0] imem_m [256];
  logic [7:0]  log_m  [4];
  bit          log_ok [4];
  int          cnt_m, wp_m;
  bit          ovf_m, armed_m, inack_m, iv_m, rd_ok;
  logic [10:0] instr_m;
  logic [7:0]  rd_m;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic store_pulse(input logic [7:0] d, output int acks);
    acks    = 0;
    st_req  = 1'b1;
    st_data = d;
    for (int c = 0; c < 2; c++) begin
      step();
      if (st_ack === 1'b1) acks++;
    end
    st_req = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      if (st_ack === 1'b1) acks++;
    end
    $display("store pulse data=%h acks=%0d count=%0d overflow=%b", d, acks, log_count, overflow);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    st_req = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic run_cycle();
    if (rst) begin
      instr_m = '0;
      iv_m    = 1'b0;
      rd_m    = '0;
      rd_ok   = 1'b1;
      cnt_m   = 0;
      wp_m    = 0;
      ovf_m   = 1'b0;
      armed_m = 1'b0;
      inack_m = 1'b0;
    end else begin
      if (prog_we) begin
        iv_m = 1'b0;
        imem_m[prog_addr] = prog_data;
      end else begin
        instr_m = imem_m[pc];
        iv_m    = 1'b1;
      end
      rd_m  = log_m[rd_addr];
      rd_ok = log_ok[rd_addr];
      if (inack_m) begin
        inack_m = 1'b0;
      end else if (!armed_m) begin
        armed_m = !st_req;
      end else if (st_req) begin
        inack_m = 1'b1;
        armed_m = 1'b0;
        if (cnt_m < 4) begin
          log_m[wp_m]  = st_data;
          log_ok[wp_m] = 1'b1;
          wp_m  = (wp_m + 1) % 4;
          cnt_m = cnt_m + 1;
        end else begin
          ovf_m = 1'b1;
        end
      end
    end
    step();
    chk("rnd_instr", 32'(instr), 32'(instr_m));
    chk("rnd_instr_valid", 32'(instr_valid), 32'(iv_m));
    chk("rnd_st_ack", 32'(st_ack), 32'(inack_m));
    chk("rnd_log_count", 32'(log_count), 32'(cnt_m));
    chk("rnd_overflow", 32'(overflow), 32'(ovf_m));
    if (rd_ok) chk("rnd_rd_data", 32'(rd_data), 32'(rd_m));
    if (inack_m) $display("rnd store data=%h count=%0d overflow=%b", st_data, cnt_m, ovf_m);
  endtask

  initial begin
    int acks;
    rst = 1'b1; pc = '0; st_req = 1'b0; st_data = '0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0; rd_addr = '0;
    step();
    step();
    chk("reset_instr", 32'(instr), 32'h0);
    chk("reset_instr_valid", 32'(instr_valid), 32'h0);
    chk("reset_st_ack", 32'(st_ack), 32'h0);
    chk("reset_rd_data", 32'(rd_data), 32'h0);
    chk("reset_log_count", 32'(log_count), 32'h0);
    chk("reset_overflow", 32'(overflow), 32'h0);
    rst = 1'b0;

    // Load three words, fetch them, then one long st_req level.
    vecs[0]  = '{1'b1, 8'd0, 11'h00F, 8'd0, 1'b0, 8'h00, 2'd0, 11'h000, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 8'd1, 11'h011, 8'd0, 1'b0, 8'h00, 2'd0, 11'h000, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 8'd2, 11'h036, 8'd0, 1'b0, 8'h00, 2'd0, 11'h000, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 8'd0, 11'h000, 8'd0, 1'b0, 8'h00, 2'd0, 11'h00F, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 8'd0, 11'h000, 8'd1, 1'b0, 8'h00, 2'd0, 11'h011, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 8'd0, 11'h000, 8'd2, 1'b1, 8'hA5, 2'd0, 11'h036, 1'b1, 1'b1, 3'd1, 1'b0, 8'h00};
    vecs[6]  = '{1'b0, 8'd0, 11'h000, 8'd2, 1'b1, 8'hA5, 2'd0, 11'h036, 1'b1, 1'b0, 3'd1, 1'b0, 8'h00};
    vecs[7]  = '{1'b0, 8'd0, 11'h000, 8'd2, 1'b1, 8'hA5, 2'd0, 11'h036, 1'b1, 1'b0, 3'd1, 1'b0, 8'h00};
    vecs[8]  = '{1'b0, 8'd0, 11'h000, 8'd2, 1'b1, 8'hA5, 2'd0, 11'h036, 1'b1, 1'b0, 3'd1, 1'b0, 8'h00};
    vecs[9]  = '{1'b0, 8'd0, 11'h000, 8'd2, 1'b1, 8'hA5, 2'd0, 11'h036, 1'b1, 1'b0, 3'd1, 1'b0, 8'h00};
    vecs[10] = '{1'b0, 8'd0, 11'h000, 8'd2, 1'b0, 8'h00, 2'd0, 11'h036, 1'b1, 1'b0, 3'd1, 1'b0, 8'h00};
    vecs[11] = '{1'b0, 8'd0, 11'h000, 8'd2, 1'b0, 8'h00, 2'd0, 11'h036, 1'b1, 1'b0, 3'd1, 1'b1, 8'hA5};

    for (int i = 0; i < 12; i++) begin
      prog_we   = vecs[i].prog_we;
      prog_addr = vecs[i].prog_addr;
      prog_data = vecs[i].prog_data;
      pc        = vecs[i].pc;
      st_req    = vecs[i].st_req;
      st_data   = vecs[i].st_data;
      rd_addr   = vecs[i].rd_addr;
      step();
      chk($sformatf("vec%0d_instr", i), 32'(instr), 32'(vecs[i].exp_instr));
      chk($sformatf("vec%0d_instr_valid", i), 32'(instr_valid), 32'(vecs[i].exp_iv));
      chk($sformatf("vec%0d_st_ack", i), 32'(st_ack), 32'(vecs[i].exp_ack));
      chk($sformatf("vec%0d_log_count", i), 32'(log_count), 32'(vecs[i].exp_cnt));
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].exp_rd));
      $display("vec %0d pc=%h instr=%h valid=%b ack=%b count=%0d", i, pc, instr, instr_valid, st_ack, log_count);
    end
    prog_we = 1'b0;

    // Fill the 4-entry log, then one more store into a full log.
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      store_pulse(8'(i), acks);
      chk($sformatf("fill%0d_acks", i), 32'(acks), 32'd1);
    end
    chk("full_overflow_before", 32'(overflow), 32'h0);
    store_pulse(8'h05, acks);
    chk("full_fifth_acks", 32'(acks), 32'd1);
    chk("full_log_count", 32'(log_count), 32'd4);
    chk("full_overflow", 32'(overflow), 32'h1);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      step();
      chk($sformatf("full_log%0d", i), 32'(rd_data), 32'(i + 1));
    end

    // Same-cycle store and read of log[2]: old data first, new data next.
    do_reset();
    store_pulse(8'h10, acks);
    store_pulse(8'h20, acks);
    rd_addr = 2'd2;
    st_req  = 1'b1;
    st_data = 8'h33;
    step();
    chk("rbw_ack", 32'(st_ack), 32'h1);
    chk("rbw_old", 32'(rd_data), 32'h03);
    step();
    chk("rbw_new", 32'(rd_data), 32'h33);
    st_req = 1'b0;
    step();
    step();

    // st_req held high through reset must not create a store.
    st_req  = 1'b1;
    st_data = 8'h77;
    rst     = 1'b1;
    step();
    step();
    rst  = 1'b0;
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (st_ack !== 1'b0) acks++;
    end
    chk("held_req_acks", 32'(acks), 32'd0);
    chk("held_req_count", 32'(log_count), 32'd0);
    st_req = 1'b0;
    step();
    st_req = 1'b1;
    step();
    chk("rearm_ack", 32'(st_ack), 32'h1);
    chk("rearm_count", 32'(log_count), 32'd1);
    // Reset while in the acknowledge cycle.
    rst = 1'b1;
    step();
    chk("abort_ack", 32'(st_ack), 32'h0);
    chk("abort_count", 32'(log_count), 32'd0);
    rst    = 1'b0;
    st_req = 1'b0;
    step();

    // Randomized phase against the model.
    for (int i = 0; i < 4; i++) log_ok[i] = 1'b0;
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    for (int a = 0; a < 256; a++) begin
      prog_we   = 1'b1;
      prog_addr = 8'(a);
      prog_data = 11'($urandom_range(0, 2047));
      pc        = 8'($urandom_range(0, 255));
      st_req    = 1'b0;
      run_cycle();
    end
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 63) == 0);
      prog_we   = !rst && ($urandom_range(0, 3) == 0);
      prog_addr = 8'($urandom_range(0, 255));
      prog_data = 11'($urandom_range(0, 2047));
      pc        = 8'($urandom_range(0, 255));
      rd_addr   = 2'($urandom_range(0, 3));
      st_data   = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) st_req = ~st_req;
      run_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
